// File: rtl/led_panel_scan.sv
// led_panel_scan: HUB75-style row scan engine driven from a 3-bit-per-pixel framebuffer
// that an on-chip 8N1 UART receiver loads; optional diagonal test pattern.
module led_panel_scan #(
  parameter int COLS         = 8,
  parameter int ROW_BITS     = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_data,
  input  logic                mode,
  output logic                red_out,
  output logic                green_out,
  output logic                blue_out,
  output logic                blank_out,
  output logic [ROW_BITS-1:0] row_out,
  output logic                sclk_out,
  output logic                latch_out,
  output logic                rx_err
);
  localparam int NPIX   = (2 ** ROW_BITS) * COLS;
  localparam int PTR_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W  = $clog2(COLS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  // SHIFT: clock one row out, 2 cycles/column | BLANK: panel off, row address update
  // LATCH: strobe shifted row into drivers    | SHOW: panel on for HOLD_CYCLES
  typedef enum logic [1:0] {S_SHIFT, S_BLANK, S_LATCH, S_SHOW} scan_t;
  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} uart_t;

  scan_t               state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                ph_q, ph_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                mode_row_q, mode_row_d;

  logic [2:0]          rgb_q, rgb_d;
  logic                sclk_q, sclk_d, latch_q, latch_d, blank_q, blank_d;
  logic [ROW_BITS-1:0] row_out_q, row_out_d;

  logic [2:0]          fb_q [NPIX];
  logic [PTR_W-1:0]    wr_ptr_q, rd_idx;
  logic [31:0]         diag;
  logic [2:0]          pix;

  uart_t               ust_q, ust_d;
  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  logic [BAUD_W-1:0]   bcnt_q, bcnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          sh_q, sh_d;
  logic                byte_vld_q, byte_vld_d, rx_err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SHIFT;
      col_q      <= '0;
      ph_q       <= 1'b0;
      row_q      <= '0;
      hold_q     <= '0;
      mode_row_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      ph_q       <= ph_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      mode_row_q <= mode_row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    ph_d       = ph_q;
    row_d      = row_q;
    hold_d     = hold_q;
    mode_row_d = mode_row_q;
    unique case (state_q)
      S_SHIFT: begin
        if (!ph_q) begin
          ph_d = 1'b1;
          if (col_q == '0) mode_row_d = mode;
        end else begin
          ph_d = 1'b0;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = S_BLANK;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_SHOW;
        hold_d  = HOLD_W'(HOLD_CYCLES - 1);
      end
      S_SHOW: begin
        if (hold_q == '0) begin
          state_d = S_SHIFT;
          row_d   = row_q + ROW_BITS'(1);
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
    endcase
  end

  // Column 0 uses the live mode input; the rest of the row uses the value captured there.
  assign rd_idx = PTR_W'(32'(row_q) * COLS + 32'(col_q));
  assign diag   = 32'(row_q) + 32'(col_q);
  assign pix    = ((col_q == '0) ? mode : mode_row_q) ? diag[2:0] : fb_q[rd_idx];

  always_comb begin
    rgb_d     = 3'b000;
    sclk_d    = 1'b0;
    latch_d   = 1'b0;
    blank_d   = 1'b1;
    row_out_d = row_out_q;
    unique case (state_q)
      S_SHIFT: begin
        if (!ph_q) begin
          rgb_d = pix;
        end else begin
          rgb_d  = rgb_q;
          sclk_d = 1'b1;
        end
      end
      S_BLANK: row_out_d = row_q;
      S_LATCH: latch_d = 1'b1;
      S_SHOW:  blank_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q     <= 3'b000;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      blank_q   <= 1'b1;
      row_out_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      blank_q   <= blank_d;
      row_out_q <= row_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ust_q      <= U_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      bcnt_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      byte_vld_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      ust_q      <= ust_d;
      rx_s1_q    <= uart_data;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      bcnt_q     <= bcnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      byte_vld_q <= byte_vld_d;
      rx_err_q   <= err_d;
    end
  end

  always_comb begin
    ust_d  = ust_q;
    bcnt_d = bcnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    case (ust_q)
      U_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          ust_d  = U_START;
          bcnt_d = BAUD_W'(CLKS_PER_BIT / 2 - 1);
        end
      end
      U_START: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BAUD_W'(1);
        end else if (!rx_s2_q) begin
          ust_d  = U_DATA;
          bcnt_d = BAUD_W'(CLKS_PER_BIT - 1);
          bit_d  = '0;
        end else begin
          ust_d = U_IDLE;
        end
      end
      U_DATA: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BAUD_W'(1);
        end else begin
          sh_d   = {rx_s2_q, sh_q[7:1]};
          bcnt_d = BAUD_W'(CLKS_PER_BIT - 1);
          if (bit_q == 3'd7) ust_d = U_STOP;
          else               bit_d = bit_q + 3'd1;
        end
      end
      U_STOP: begin
        if (bcnt_q != '0) bcnt_d = bcnt_q - BAUD_W'(1);
        else              ust_d  = rx_s2_q ? U_IDLE : U_WAIT;
      end
      U_WAIT:  if (rx_s2_q) ust_d = U_IDLE;
      default: ust_d = U_IDLE;
    endcase
  end

  always_comb begin
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (ust_q == U_STOP && bcnt_q == '0) begin
      if (rx_s2_q) byte_vld_d = 1'b1;
      else         err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPIX; i++) fb_q[i] <= 3'b000;
      wr_ptr_q <= '0;
    end else if (byte_vld_q) begin
      if (sh_q == 8'hFF) begin
        wr_ptr_q <= '0;
      end else begin
        fb_q[wr_ptr_q] <= sh_q[2:0];
        wr_ptr_q       <= (wr_ptr_q == PTR_W'(NPIX - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
    end
  end

  assign red_out   = rgb_q[0];
  assign green_out = rgb_q[1];
  assign blue_out  = rgb_q[2];
  assign sclk_out  = sclk_q;
  assign latch_out = latch_q;
  assign blank_out = blank_q;
  assign row_out   = row_out_q;
  assign rx_err    = rx_err_q;

endmodule
